// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART (TXD/RXD/CON at 0x4000_0018..0x4000_0020); reads are combinational, writes land next cycle.
// TX starts the cycle after a CON write and takes 10*DIV cycles; no backpressure, firmware polls TX_IDLE/RX_RDY.
module uart_peripheral #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] rdata,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    txd_reg_q, txd_reg_d;
    logic [7:0]    rxd_reg_q, rxd_reg_d;
    logic          tx_en_q, tx_en_d, rx_en_q, rx_en_d;
    logic          tx_done_q, tx_done_d, rx_rdy_q, rx_rdy_d;

    logic [1:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;

    logic con_we, txd_we, tx_busy, tx_cnt_end, rx_cnt_end;
    logic tx_start, tx_done_set, rx_load;

    assign con_we     = we && (addr == ADDR_CON);
    assign txd_we     = we && (addr == ADDR_TXD);
    assign tx_busy    = (tx_state_q != S_IDLE);
    assign tx_cnt_end = (tx_cnt_q == CNT_LAST);
    assign rx_cnt_end = (rx_cnt_q == CNT_LAST);
    // The last stop-bit cycle counts as idle so a CON write there chains frames without a gap.
    assign tx_start   = con_we && wdata[0] &&
                        (!tx_busy || (tx_state_q == S_STOP && tx_cnt_end));
    assign uart_txd   = tx_line_q;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_line_d   = tx_line_q;
        tx_done_set = 1'b0;
        case (tx_state_q)
            S_START: begin
                if (tx_cnt_end) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = S_DATA;
                    tx_line_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (tx_cnt_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (tx_cnt_end) begin
                    tx_cnt_d    = '0;
                    tx_state_d  = S_IDLE;
                    tx_done_set = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: ;
        endcase
        if (tx_start) begin
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_shift_d = txd_reg_q;
            tx_line_d  = 1'b0;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_load    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_s2_q && rx_prev_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
            end
            S_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (rx_cnt_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                if (rx_cnt_end) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    rx_load    = rx_s2_q && rx_en_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Hardware status set beats a simultaneous clear by a CON write.
    always_comb begin
        txd_reg_d = txd_we ? wdata[7:0] : txd_reg_q;
        rxd_reg_d = rx_load ? rx_shift_q : rxd_reg_q;
        tx_en_d   = con_we ? wdata[0] : tx_en_q;
        rx_en_d   = con_we ? wdata[1] : rx_en_q;
        tx_done_d = tx_done_set ? 1'b1 : (con_we ? 1'b0 : tx_done_q);
        rx_rdy_d  = rx_load ? 1'b1 : (con_we ? 1'b0 : rx_rdy_q);
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (addr)
                ADDR_TXD: rdata = {24'd0, txd_reg_q};
                ADDR_RXD: rdata = {24'd0, rxd_reg_q};
                ADDR_CON: rdata = {27'd0, tx_en_q & ~tx_busy, rx_rdy_q, tx_done_q, rx_en_q, tx_en_q};
                default:  rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            txd_reg_q  <= '0;
            rxd_reg_q  <= '0;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            tx_done_q  <= 1'b0;
            rx_rdy_q   <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            txd_reg_q  <= txd_reg_d;
            rxd_reg_q  <= rxd_reg_d;
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
            tx_done_q  <= tx_done_d;
            rx_rdy_q   <= rx_rdy_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_s1_q    <= uart_rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end
endmodule
